eco32_core_lsu_dcu_xctl: RTL and testbench
==========================================

Name: eco32_core_lsu_dcu_xctl

Overview:
Line-transfer sequencer for the external (xi/xo) port of the DCU byte-wide data memory.
- Fill: accepts a 64-bit line and writes it as 8 byte-strobes. External writes clear the per-byte ben flag.
- Flush: reads the 8 bytes of a line and collects data plus ben flags into one 64-bit word with an 8-bit mask.
- Offers the collected line on a valid/ack write-back channel. Clean lines (mask all zero) are not offered.
- Sits between the DCU miss/evict logic and the data memory; it is the only driver of the memory's x-port.

Parameters:
PAGE_ADDR_WIDTH, 5, page index width; must match the data memory instance.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_stb  in  1  transfer request
req_ack  out  1  request accepted (combinational: idle && req_stb)
req_op  in  1  0 = fill, 1 = flush
req_tid  in  1  thread id
req_wid  in  1  way id
req_page  in  PAGE_ADDR_WIDTH  page index
req_data  in  64  fill line; byte k = bits [8k+7:8k]
busy  out  1  high whenever FSM is not IDLE
done  out  1  one-cycle pulse when a transfer completes
wb_val  out  1  write-back line valid
wb_ack  in  1  write-back accepted
wb_tid  out  1  captured tid
wb_wid  out  1  captured wid
wb_page  out  PAGE_ADDR_WIDTH  captured page
wb_data  out  64  collected line
wb_ben  out  8  collected byte-enable mask
xm_stb  out  1  memory x-port strobe
xm_wen  out  1  memory x-port write enable
xm_tid  out  1  memory x-port tid
xm_wid  out  1  memory x-port wid
xm_page  out  PAGE_ADDR_WIDTH  memory x-port page
xm_offset  out  3  memory x-port byte offset
xm_data  out  8  memory x-port write byte
xm_val  in  1  read data valid (1 cycle after read strobe)
xm_ben  in  1  read byte-enable
xm_rdata  in  8  read byte

Behaviour:
- Reset: all outputs and registers 0; FSM = IDLE. Reset mid-transfer aborts it: no done pulse, captured line discarded.
- FSM states: IDLE, FILL, RD, DRAIN, WB, DONE.
- IDLE: req_ack = req_stb. On accept, latch tid, wid, page and data; go to FILL (op = 0) or RD (op = 1).
- Requests are never accepted outside IDLE, so req_stb held there simply waits.
- FILL: 8 cycles. Each cycle drives xm_stb = 1, xm_wen = 1, offset = cnt (0..7), xm_data = byte cnt. After offset 7, go to DONE.
- RD: 8 cycles with xm_stb = 1, xm_wen = 0, offset 0..7. After offset 7, go to DRAIN.
- Capture: every xm_val in RD/DRAIN stores {xm_ben, xm_rdata} at position rcnt, then increments rcnt (3-bit, plus done flag).
- DRAIN: leave when the 8th byte is captured, which is the cycle after the last strobe.
  - If the captured mask is nonzero, go to WB.
  - If the mask is all zero (clean line), go straight to DONE; wb_val never asserts.
- WB: wb_val = 1 with data, ben, tid, wid and page stable. On wb_ack, go to DONE. wb_ack in any other state is ignored.
- DONE: done = 1 for one cycle, then IDLE. The next req_ack is possible in the following cycle.
- xm_val outside RD/DRAIN is ignored.
- xm_tid, xm_wid and xm_page come from the latched request. They and xm_offset/xm_data are 0 when xm_stb = 0.
- Latency from accept cycle A:
  - Fill: writes in cycles A+1..A+8, done in A+9.
  - Flush: strobes in A+1..A+8, last capture in A+9, wb_val from A+10; done in the cycle after wb_ack (clean line: done in A+10).
- Counters are 3-bit and wrap after 7; the transition is taken on cnt == 7, with no extra cycle.

Decomposition:
- Shared package eco32_core_lsu_dcu_pkg: FSM state encoding, OP_FILL/OP_FLUSH constants, LINE_BYTES = 8.
- One sub-module, eco32_core_lsu_dcu_xctl_collect: byte/ben shift-in collector with rcnt and a full flag.
- FSM and port muxing stay in the top module.

Test Plan:
- Fill: req_op = 0, page 5, wid 1, tid 0, data 0x8877665544332211 → 8 write strobes, offsets 0..7 with bytes 0x11..0x88; done in A+9.
- Flush, dirty: memory model returns ben = 1 only at offset 3 with byte 0xAB, other bytes 0x00 → wb_ben = 0x08, wb_data = 0x00000000AB000000. Hold wb_ack low 5 cycles: wb_val and data stay stable. Ack → done pulse next cycle.
- Flush, clean: all ben = 0 → no wb_val; done at A+10; busy low at A+11.
- Back-to-back: req_stb held high across two fills → second req_ack exactly one cycle after the first done; no strobe overlap.
- Reset mid-flush: rst_n low during RD offset 4 → all outputs 0 immediately. After release, a spurious xm_val is ignored and the next flush collects correctly.
- Stray inputs: wb_ack pulsed in IDLE and xm_val in FILL → no state change and no wb_val.

Source files
------------

// File: rtl/eco32_core_lsu_dcu_pkg.sv
// Shared types and constants for the DCU line-transfer sequencer.
// Holds the FSM encoding, request op codes and the byte-lane helpers.
package eco32_core_lsu_dcu_pkg;

    localparam int LINE_BYTES = 8;

    localparam logic OP_FILL  = 1'b0;
    localparam logic OP_FLUSH = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RD    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WB    = 3'd4,
        ST_DONE  = 3'd5
    } xctl_state_e;

    // One collected memory byte together with its dirty flag.
    typedef struct packed {
        logic       ben;
        logic [7:0] data;
    } xbyte_t;

    function automatic logic [7:0] get_byte(input logic [63:0] line, input logic [2:0] idx);
        return line[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/eco32_core_lsu_dcu_xctl_if.sv
// Bundle of the request, write-back and memory x-port signals of the sequencer.
// The slave modport is the sequencer's view, the master modport is its environment.
interface eco32_core_lsu_dcu_xctl_if #(
    parameter int PAGE_ADDR_WIDTH = 5
);
    logic                       req_stb;
    logic                       req_ack;
    logic                       req_op;
    logic                       req_tid;
    logic                       req_wid;
    logic [PAGE_ADDR_WIDTH-1:0] req_page;
    logic [63:0]                req_data;

    logic                       busy;
    logic                       done;

    logic                       wb_val;
    logic                       wb_ack;
    logic                       wb_tid;
    logic                       wb_wid;
    logic [PAGE_ADDR_WIDTH-1:0] wb_page;
    logic [63:0]                wb_data;
    logic [7:0]                 wb_ben;

    logic                       xm_stb;
    logic                       xm_wen;
    logic                       xm_tid;
    logic                       xm_wid;
    logic [PAGE_ADDR_WIDTH-1:0] xm_page;
    logic [2:0]                 xm_offset;
    logic [7:0]                 xm_data;
    logic                       xm_val;
    logic                       xm_ben;
    logic [7:0]                 xm_rdata;

    modport slave (
        input  req_stb, req_op, req_tid, req_wid, req_page, req_data,
        output req_ack, busy, done,
        output wb_val, wb_tid, wb_wid, wb_page, wb_data, wb_ben,
        input  wb_ack,
        output xm_stb, xm_wen, xm_tid, xm_wid, xm_page, xm_offset, xm_data,
        input  xm_val, xm_ben, xm_rdata
    );

    modport master (
        output req_stb, req_op, req_tid, req_wid, req_page, req_data,
        input  req_ack, busy, done,
        input  wb_val, wb_tid, wb_wid, wb_page, wb_data, wb_ben,
        output wb_ack,
        input  xm_stb, xm_wen, xm_tid, xm_wid, xm_page, xm_offset, xm_data,
        output xm_val, xm_ben, xm_rdata
    );

endinterface

// File: rtl/eco32_core_lsu_dcu_xctl_collect.sv
// Shift-in collector for flush reads: stores each returned byte and its ben flag
// at the next line position, and flags the cycle the eighth byte arrives.
module eco32_core_lsu_dcu_xctl_collect
    import eco32_core_lsu_dcu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        cap_en,
    input  logic        val,
    input  logic        ben,
    input  logic [7:0]  rdata,
    output logic [63:0] line,
    output logic [7:0]  mask,
    output logic [7:0]  mask_nxt,
    output logic        last
);

    logic [2:0] rcnt;
    logic       full;
    logic       take;
    xbyte_t     in_byte;

    assign in_byte = '{ben: ben, data: rdata};
    assign take    = cap_en && val && !full;
    assign last    = take && (rcnt == 3'(LINE_BYTES - 1));

    // Mask as it will look after this cycle's capture, so the sequencer can
    // decide clean/dirty in the same cycle the last byte lands.
    always_comb begin
        mask_nxt = mask;
        if (take) mask_nxt[rcnt] = in_byte.ben;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line <= '0;
            mask <= '0;
            rcnt <= '0;
            full <= 1'b0;
        end else if (clr) begin
            line <= '0;
            mask <= '0;
            rcnt <= '0;
            full <= 1'b0;
        end else if (take) begin
            line[{rcnt, 3'b000} +: 8] <= in_byte.data;
            mask[rcnt]                <= in_byte.ben;
            rcnt                      <= rcnt + 3'd1;
            if (rcnt == 3'(LINE_BYTES - 1)) full <= 1'b1;
        end
    end

endmodule

// File: rtl/eco32_core_lsu_dcu_xctl.sv
// Line-transfer sequencer for the DCU data memory x-port: fills a line as eight
// byte writes, or flushes one by reading eight bytes and offering dirty lines.
module eco32_core_lsu_dcu_xctl
    import eco32_core_lsu_dcu_pkg::*;
#(
    parameter int PAGE_ADDR_WIDTH = 5
) (
    input logic                  clk,
    input logic                  rst_n,
    eco32_core_lsu_dcu_xctl_if.slave bus
);

    xctl_state_e                state;
    logic [2:0]                 cnt;
    logic                       lat_tid;
    logic                       lat_wid;
    logic [PAGE_ADDR_WIDTH-1:0] lat_page;
    logic [63:0]                lat_data;

    logic                       idle;
    logic                       accept;
    logic                       xm_act;
    logic                       cap_en;
    logic [63:0]                col_line;
    logic [7:0]                 col_mask;
    logic [7:0]                 col_mask_nxt;
    logic                       col_last;

    assign idle   = (state == ST_IDLE);
    assign accept = idle && bus.req_stb;
    assign xm_act = (state == ST_FILL) || (state == ST_RD);
    // Read data trails the strobe by one cycle, so DRAIN still captures.
    assign cap_en = (state == ST_RD) || (state == ST_DRAIN);

    eco32_core_lsu_dcu_xctl_collect u_collect (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept),
        .cap_en   (cap_en),
        .val      (bus.xm_val),
        .ben      (bus.xm_ben),
        .rdata    (bus.xm_rdata),
        .line     (col_line),
        .mask     (col_mask),
        .mask_nxt (col_mask_nxt),
        .last     (col_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            lat_tid  <= 1'b0;
            lat_wid  <= 1'b0;
            lat_page <= '0;
            lat_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (bus.req_stb) begin
                        lat_tid  <= bus.req_tid;
                        lat_wid  <= bus.req_wid;
                        lat_page <= bus.req_page;
                        lat_data <= bus.req_data;
                        state    <= (bus.req_op == OP_FLUSH) ? ST_RD : ST_FILL;
                    end
                end
                ST_FILL: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'(LINE_BYTES - 1)) state <= ST_DONE;
                end
                ST_RD: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'(LINE_BYTES - 1)) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Clean lines skip the write-back channel entirely.
                    if (col_last) state <= (col_mask_nxt != 8'd0) ? ST_WB : ST_DONE;
                end
                ST_WB: begin
                    if (bus.wb_ack) state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ack   = accept;
    assign bus.busy      = !idle;
    assign bus.done      = (state == ST_DONE);

    assign bus.xm_stb    = xm_act;
    assign bus.xm_wen    = (state == ST_FILL);
    assign bus.xm_tid    = xm_act && lat_tid;
    assign bus.xm_wid    = xm_act && lat_wid;
    assign bus.xm_page   = xm_act ? lat_page : '0;
    assign bus.xm_offset = xm_act ? cnt : 3'd0;
    assign bus.xm_data   = (state == ST_FILL) ? get_byte(lat_data, cnt) : 8'd0;

    assign bus.wb_val    = (state == ST_WB);
    assign bus.wb_tid    = bus.wb_val && lat_tid;
    assign bus.wb_wid    = bus.wb_val && lat_wid;
    assign bus.wb_page   = bus.wb_val ? lat_page : '0;
    assign bus.wb_data   = bus.wb_val ? col_line : 64'd0;
    assign bus.wb_ben    = bus.wb_val ? col_mask : 8'd0;

endmodule

// File: tb/tb_eco32_core_lsu_dcu_xctl.sv
// Bench for the DCU line-transfer sequencer: table rows, hand-written corner
// sequences and random transactions against a byte-array memory model.
module tb_eco32_core_lsu_dcu_xctl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eco32_core_lsu_dcu_xctl_if #(.PAGE_ADDR_WIDTH(5)) ifc ();

    eco32_core_lsu_dcu_xctl #(.PAGE_ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int checks = 0;
    int failures = 0;

    // Memory contents seen by flush reads; set by the stimulus before each flush.
    logic [7:0] mem_b [8];
    logic       mem_e [8];
    logic       mem_val = 1'b0;
    logic       mem_ben_q = 1'b0;
    logic [7:0] mem_rd_q = 8'd0;
    logic       spur_val = 1'b0;
    logic       spur_ben = 1'b0;
    logic [7:0] spur_data = 8'd0;

    assign ifc.xm_val   = mem_val | spur_val;
    assign ifc.xm_ben   = spur_val ? spur_ben : mem_ben_q;
    assign ifc.xm_rdata = spur_val ? spur_data : mem_rd_q;

    always @(posedge clk) begin
        mem_val   <= ifc.xm_stb && !ifc.xm_wen;
        mem_ben_q <= mem_e[ifc.xm_offset];
        mem_rd_q  <= mem_b[ifc.xm_offset];
    end

    typedef struct {
        logic        op;
        logic [4:0]  page;
        logic        wid;
        logic        tid;
        logic [63:0] data;
        logic [63:0] mbytes;
        logic [7:0]  mben;
        int          dly;
        logic [63:0] exp_d;
        logic [7:0]  exp_b;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic load_mem(input logic [63:0] bytes, input logic [7:0] bens);
        for (int k = 0; k < 8; k++) begin
            mem_b[k] = 8'((bytes >> (8 * k)) & 64'hFF);
            mem_e[k] = bens[k];
        end
    endtask

    // Reference: a flush returns every memory byte in order plus the ben flags.
    task automatic ref_flush(output logic [63:0] d, output logic [7:0] b);
        d = 64'd0;
        b = 8'd0;
        for (int k = 0; k < 8; k++) begin
            d = d | (64'(mem_b[k]) << (8 * k));
            b[k] = mem_e[k];
        end
    endtask

    task automatic issue(input logic op, input logic [4:0] pg, input logic w, input logic t,
                         input logic [63:0] d, output bit ok);
        ifc.req_op   = op;
        ifc.req_page = pg;
        ifc.req_wid  = w;
        ifc.req_tid  = t;
        ifc.req_data = d;
        ifc.req_stb  = 1'b1;
        #1;
        for (int n = 0; n < 30 && !ifc.req_ack; n++) begin
            @(negedge clk);
            #1;
        end
        ok = ifc.req_ack;
        chk("req_ack", 128'(ok), 128'(1'b1));
    endtask

    // Called in the accept cycle; checks A+1..A+10 of a fill.
    task automatic fill_body(input logic [63:0] d, input logic [4:0] pg, input logic w,
                             input logic t, input bit hold, input logic [63:0] nd);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                ifc.req_stb = hold;
                if (hold) ifc.req_data = nd;
            end
            #1;
            chk("fill_xm",
                128'({ifc.xm_stb, ifc.xm_wen, ifc.xm_offset, ifc.xm_data, ifc.xm_page, ifc.xm_wid, ifc.xm_tid}),
                128'({1'b1, 1'b1, 3'(k), 8'((d >> (8 * k)) & 64'hFF), pg, w, t}));
            chk("fill_ctl", 128'({ifc.req_ack, ifc.wb_val, ifc.done, ifc.busy}), 128'(4'b0001));
        end
        @(negedge clk);
        chk("fill_done", 128'({ifc.done, ifc.busy, ifc.xm_stb, ifc.req_ack}), 128'(4'b1100));
        @(negedge clk);
        chk("fill_idle", 128'({ifc.done, ifc.busy, ifc.req_ack}), 128'({2'b00, hold}));
    endtask

    task automatic flush_body(input logic [4:0] pg, input logic w, input logic t, input int dly,
                              input logic [63:0] exp_d, input logic [7:0] exp_b);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) ifc.req_stb = 1'b0;
            chk("rd_xm",
                128'({ifc.xm_stb, ifc.xm_wen, ifc.xm_offset, ifc.xm_data, ifc.xm_page, ifc.xm_wid, ifc.xm_tid}),
                128'({1'b1, 1'b0, 3'(k), 8'd0, pg, w, t}));
        end
        @(negedge clk);
        chk("drain", 128'({ifc.busy, ifc.wb_val, ifc.done, ifc.xm_stb}), 128'(4'b1000));
        @(negedge clk);
        if (exp_b != 8'd0) begin
            for (int i = 0; i <= dly; i++) begin
                chk("wb_line",
                    128'({ifc.wb_val, ifc.done, ifc.wb_data, ifc.wb_ben, ifc.wb_tid, ifc.wb_wid, ifc.wb_page}),
                    128'({1'b1, 1'b0, exp_d, exp_b, t, w, pg}));
                if (i < dly) @(negedge clk);
            end
            ifc.wb_ack = 1'b1;
            @(negedge clk);
            ifc.wb_ack = 1'b0;
            chk("wb_done", 128'({ifc.done, ifc.wb_val, ifc.busy}), 128'(3'b101));
            @(negedge clk);
            chk("wb_idle", 128'({ifc.done, ifc.busy, ifc.wb_val}), 128'(3'b000));
        end else begin
            chk("clean_done", 128'({ifc.done, ifc.wb_val, ifc.busy}), 128'(3'b101));
            @(negedge clk);
            chk("clean_idle", 128'({ifc.done, ifc.busy, ifc.wb_val}), 128'(3'b000));
        end
    endtask

    task automatic run_fill(input logic [4:0] pg, input logic w, input logic t, input logic [63:0] d);
        bit ok;
        issue(1'b0, pg, w, t, d, ok);
        if (ok) fill_body(d, pg, w, t, 1'b0, 64'd0);
        else ifc.req_stb = 1'b0;
    endtask

    task automatic run_flush(input logic [4:0] pg, input logic w, input logic t, input int dly,
                             input logic [63:0] exp_d, input logic [7:0] exp_b);
        bit ok;
        issue(1'b1, pg, w, t, 64'd0, ok);
        if (ok) flush_body(pg, w, t, dly, exp_d, exp_b);
        else ifc.req_stb = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic [7:0]  rb;
        bit          ok;

        ifc.req_stb = 1'b0; ifc.req_op = 1'b0; ifc.req_tid = 1'b0; ifc.req_wid = 1'b0;
        ifc.req_page = 5'd0; ifc.req_data = 64'd0; ifc.wb_ack = 1'b0;
        load_mem(64'd0, 8'd0);

        tbl[0] = '{op: 1'b0, page: 5'd5, wid: 1'b1, tid: 1'b0, data: 64'h8877665544332211,
                   mbytes: 64'd0, mben: 8'h00, dly: 0, exp_d: 64'd0, exp_b: 8'h00};
        tbl[1] = '{op: 1'b1, page: 5'd9, wid: 1'b0, tid: 1'b1, data: 64'd0,
                   mbytes: 64'h00000000AB000000, mben: 8'h08, dly: 5,
                   exp_d: 64'h00000000AB000000, exp_b: 8'h08};
        tbl[2] = '{op: 1'b1, page: 5'd17, wid: 1'b1, tid: 1'b1, data: 64'd0,
                   mbytes: 64'h1122334455667788, mben: 8'h00, dly: 0,
                   exp_d: 64'd0, exp_b: 8'h00};
        tbl[3] = '{op: 1'b1, page: 5'd31, wid: 1'b1, tid: 1'b0, data: 64'd0,
                   mbytes: 64'hF0E1D2C3B4A59687, mben: 8'h81, dly: 1,
                   exp_d: 64'hF0E1D2C3B4A59687, exp_b: 8'h81};

        // reset state
        repeat (2) @(negedge clk);
        chk("reset_out",
            128'({ifc.busy, ifc.done, ifc.wb_val, ifc.xm_stb, ifc.xm_offset, ifc.xm_data, ifc.req_ack, ifc.wb_ben}),
            128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            if (tbl[i].op == 1'b0) begin
                run_fill(tbl[i].page, tbl[i].wid, tbl[i].tid, tbl[i].data);
            end else begin
                load_mem(tbl[i].mbytes, tbl[i].mben);
                run_flush(tbl[i].page, tbl[i].wid, tbl[i].tid, tbl[i].dly, tbl[i].exp_d, tbl[i].exp_b);
            end
        end

        // back-to-back fills with req_stb held high
        issue(1'b0, 5'd3, 1'b0, 1'b1, 64'h0102030405060708, ok);
        if (ok) begin
            fill_body(64'h0102030405060708, 5'd3, 1'b0, 1'b1, 1'b1, 64'hCAFEBABEDEADBEEF);
            fill_body(64'hCAFEBABEDEADBEEF, 5'd3, 1'b0, 1'b1, 1'b0, 64'd0);
        end else ifc.req_stb = 1'b0;

        // reset during RD offset 4
        load_mem(64'h1111111111111111, 8'hFF);
        issue(1'b1, 5'd12, 1'b1, 1'b1, 64'd0, ok);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) ifc.req_stb = 1'b0;
        end
        chk("rd_off4", 128'({ifc.xm_stb, ifc.xm_offset}), 128'({1'b1, 3'd4}));
        rst_n = 1'b0;
        #1;
        chk("rst_zero",
            128'({ifc.busy, ifc.done, ifc.wb_val, ifc.xm_stb, ifc.xm_wen, ifc.xm_offset, ifc.xm_data,
                  ifc.xm_page, ifc.xm_tid, ifc.xm_wid, ifc.req_ack, ifc.wb_ben, ifc.wb_data}),
            128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        spur_val = 1'b1; spur_ben = 1'b1; spur_data = 8'hEE;
        @(negedge clk);
        spur_val = 1'b0;
        chk("spur_ign", 128'({ifc.busy, ifc.wb_val, ifc.done}), 128'(0));
        load_mem(64'h00C0000000000A00, 8'h42);
        ref_flush(rd, rb);
        run_flush(5'd12, 1'b1, 1'b1, 2, rd, rb);

        // stray wb_ack in IDLE, stray xm_val during FILL
        ifc.wb_ack = 1'b1;
        @(negedge clk);
        ifc.wb_ack = 1'b0;
        chk("stray_ack", 128'({ifc.busy, ifc.wb_val, ifc.done}), 128'(0));
        spur_val = 1'b1; spur_ben = 1'b1; spur_data = 8'h5A;
        run_fill(5'd7, 1'b0, 1'b0, 64'h0F1E2D3C4B5A6978);
        spur_val = 1'b0;
        load_mem(64'h0123456789ABCDEF, 8'h00);
        run_flush(5'd7, 1'b0, 1'b0, 0, 64'd0, 8'h00);

        // random transactions against the reference model
        for (int n = 0; n < 16; n++) begin
            logic [4:0]  pg;
            logic        w, t;
            logic [63:0] d;
            logic [7:0]  be;
            pg = 5'($urandom);
            w  = 1'($urandom);
            t  = 1'($urandom);
            d  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) begin
                run_fill(pg, w, t, d);
            end else begin
                be = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                load_mem(d, be);
                ref_flush(rd, rb);
                run_flush(pg, w, t, $urandom_range(0, 3), rd, rb);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
